alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters:
  - lane 0: execute/issue path (arithmetic, branch compare, PC-relative);
  - lane 1: load/store address generation.
- Arbitrates each cycle with round-robin priority and drives the ALU inputs from the granted lane.
- Captures the ALU result and sign bits into a one-entry output register with a valid/ready handshake and a source/tag return path.
- Sits between the issue stage / LSU front end and the ALU, so the core needs no second adder.

---
 rtl/alu_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between the issue lane (0) and the
// load/store address lane (1), with a one-entry valid/ready result register.
module alu_share_arbiter #(
    parameter int unsigned LEN   = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*LEN-1:0]   req_rs1,
    input  logic [2*LEN-1:0]   req_rs2,
    input  logic [2*LEN-1:0]   req_imm,
    input  logic [2*LEN-1:0]   req_pc,
    input  logic [5:0]         req_alu_signal,
    input  logic [7:0]         req_func_code,
    input  logic [2*TAG_W-1:0] req_tag,

    output logic [LEN-1:0]     alu_rs1,
    output logic [LEN-1:0]     alu_rs2,
    output logic [LEN-1:0]     alu_imm,
    output logic [LEN-1:0]     alu_pc,
    output logic [2:0]         alu_signal,
    output logic [3:0]         alu_func_code,
    input  logic [LEN-1:0]     alu_result,
    input  logic [1:0]         alu_sign_bits,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [LEN-1:0]     out_result,
    output logic [1:0]         out_sign_bits,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_src
);

    localparam logic [2:0] ALU_NOP = 3'd0;

    logic [LEN-1:0]   rs1_lane  [2];
    logic [LEN-1:0]   rs2_lane  [2];
    logic [LEN-1:0]   imm_lane  [2];
    logic [LEN-1:0]   pc_lane   [2];
    logic [2:0]       sig_lane  [2];
    logic [3:0]       func_lane [2];
    logic [TAG_W-1:0] tag_lane  [2];

    logic             out_valid_q, out_valid_d;
    logic [LEN-1:0]   out_result_q, out_result_d;
    logic [1:0]       out_sign_bits_q, out_sign_bits_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_src_q, out_src_d;
    logic             rr_ptr_q, rr_ptr_d;

    logic             slot_free;
    logic [1:0]       grant;
    logic             gnt_lane;
    logic             fire;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rs1_lane[i]  = req_rs1[i*LEN +: LEN];
            rs2_lane[i]  = req_rs2[i*LEN +: LEN];
            imm_lane[i]  = req_imm[i*LEN +: LEN];
            pc_lane[i]   = req_pc[i*LEN +: LEN];
            sig_lane[i]  = req_alu_signal[i*3 +: 3];
            func_lane[i] = req_func_code[i*4 +: 4];
            tag_lane[i]  = req_tag[i*TAG_W +: TAG_W];
        end
    end

    assign slot_free = !out_valid_q || out_ready;

    // rst gates the grant so requesters never see an accept during reset.
    always_comb begin
        grant = 2'b00;
        if (!rst && !flush && slot_free) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign gnt_lane  = grant[1];
    assign fire      = |grant;
    assign req_ready = grant;

    // Idle cycles present a NOP so the ALU never re-executes a stale operation.
    always_comb begin
        alu_rs1       = '0;
        alu_rs2       = '0;
        alu_imm       = '0;
        alu_pc        = '0;
        alu_signal    = ALU_NOP;
        alu_func_code = 4'd0;
        if (fire) begin
            alu_rs1       = rs1_lane[gnt_lane];
            alu_rs2       = rs2_lane[gnt_lane];
            alu_imm       = imm_lane[gnt_lane];
            alu_pc        = pc_lane[gnt_lane];
            alu_signal    = sig_lane[gnt_lane];
            alu_func_code = func_lane[gnt_lane];
        end
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_sign_bits_d = out_sign_bits_q;
        out_tag_d       = out_tag_q;
        out_src_d       = out_src_q;
        rr_ptr_d        = rr_ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d     = 1'b1;
            out_result_d    = alu_result;
            out_sign_bits_d = alu_sign_bits;
            out_tag_d       = tag_lane[gnt_lane];
            out_src_d       = gnt_lane;
            rr_ptr_d        = ~gnt_lane;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_sign_bits_q <= 2'b00;
            out_tag_q       <= '0;
            out_src_q       <= 1'b0;
            rr_ptr_q        <= 1'b0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_sign_bits_q <= out_sign_bits_d;
            out_tag_q       <= out_tag_d;
            out_src_q       <= out_src_d;
            rr_ptr_q        <= rr_ptr_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_sign_bits = out_sign_bits_q;
    assign out_tag       = out_tag_q;
    assign out_src       = out_src_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, async reset sequence and
// randomized traffic against a transaction-level model; includes a simple ALU.
module tb_alu_share_arbiter;

    localparam int LEN   = 32;
    localparam int TAG_W = 4;

    localparam logic [2:0] ALU_NOP     = 3'd0;
    localparam logic [2:0] BINARY      = 3'd1;
    localparam logic [2:0] BRANCH_COND = 3'd2;
    localparam logic [2:0] MEM_ADDR    = 3'd3;
    localparam logic [2:0] PC_REL      = 3'd4;
    localparam logic [3:0] F_ADD       = 4'd0;
    localparam logic [3:0] F_SUB       = 4'd1;
    localparam logic [1:0] S_ZERO      = 2'b00;
    localparam logic [1:0] S_POS       = 2'b01;
    localparam logic [1:0] S_NEG       = 2'b10;

    typedef struct packed {
        logic [2:0]  sig;
        logic [3:0]  func;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
    } lane_t;

    typedef struct {
        logic        flush;
        logic        ordy;
        logic [1:0]  vld;
        lane_t       l0;
        lane_t       l1;
        logic [1:0]  e_rdy;
        logic [2:0]  e_sig;
        logic        e_ov;
        logic [31:0] e_res;
        logic [1:0]  e_sb;
        logic [3:0]  e_tag;
        logic        e_src;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*LEN-1:0]   req_rs1, req_rs2, req_imm, req_pc;
    logic [5:0]         req_alu_signal;
    logic [7:0]         req_func_code;
    logic [2*TAG_W-1:0] req_tag;
    logic [LEN-1:0]     alu_rs1, alu_rs2, alu_imm, alu_pc;
    logic [2:0]         alu_signal;
    logic [3:0]         alu_func_code;
    logic [LEN-1:0]     alu_result;
    logic [1:0]         alu_sign_bits;
    logic               out_valid;
    logic               out_ready;
    logic [LEN-1:0]     out_result;
    logic [1:0]         out_sign_bits;
    logic [TAG_W-1:0]   out_tag;
    logic               out_src;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.LEN(LEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_pc(req_pc),
        .req_alu_signal(req_alu_signal), .req_func_code(req_func_code), .req_tag(req_tag),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_signal(alu_signal), .alu_func_code(alu_func_code),
        .alu_result(alu_result), .alu_sign_bits(alu_sign_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_sign_bits(out_sign_bits), .out_tag(out_tag), .out_src(out_src)
    );

    function automatic logic [31:0] alu_fn(input logic [2:0] sig, input logic [3:0] func,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] imm, input logic [31:0] pc);
        case (sig)
            ALU_NOP:     return 32'd0;
            BINARY:      return (func == F_ADD) ? a + b : (func == F_SUB) ? a - b : a ^ b;
            BRANCH_COND: return a - b;
            MEM_ADDR:    return a + imm;
            PC_REL:      return pc + imm;
            default:     return a ^ b ^ imm;
        endcase
    endfunction

    function automatic logic [1:0] sign_fn(input logic [31:0] r);
        if (r == 32'd0) return S_ZERO;
        return r[31] ? S_NEG : S_POS;
    endfunction

    // External ALU stand-in, driven purely from the arbiter's ALU port.
    always_comb begin
        alu_result    = alu_fn(alu_signal, alu_func_code, alu_rs1, alu_rs2, alu_imm, alu_pc);
        alu_sign_bits = sign_fn(alu_result);
    end

    function automatic lane_t ln(input logic [2:0] sig, input logic [3:0] func,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [3:0] tag);
        lane_t l;
        l.sig = sig; l.func = func; l.rs1 = rs1; l.rs2 = rs2;
        l.imm = imm; l.pc = 32'd0; l.tag = tag;
        return l;
    endfunction

    function automatic vec_t mkv(input logic fl, input logic ordy, input logic [1:0] vld,
                                 input lane_t l0, input lane_t l1, input logic [1:0] e_rdy,
                                 input logic [2:0] e_sig, input logic e_ov,
                                 input logic [31:0] e_res, input logic [1:0] e_sb,
                                 input logic [3:0] e_tag, input logic e_src);
        vec_t v;
        v.flush = fl; v.ordy = ordy; v.vld = vld; v.l0 = l0; v.l1 = l1;
        v.e_rdy = e_rdy; v.e_sig = e_sig; v.e_ov = e_ov; v.e_res = e_res;
        v.e_sb = e_sb; v.e_tag = e_tag; v.e_src = e_src;
        return v;
    endfunction

    task automatic drive(input logic fl, input logic ordy, input logic [1:0] vld,
                         input lane_t a, input lane_t b);
        flush          = fl;
        out_ready      = ordy;
        req_valid      = vld;
        req_rs1        = {b.rs1, a.rs1};
        req_rs2        = {b.rs2, a.rs2};
        req_imm        = {b.imm, a.imm};
        req_pc         = {b.pc, a.pc};
        req_alu_signal = {b.sig, a.sig};
        req_func_code  = {b.func, a.func};
        req_tag        = {b.tag, a.tag};
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic chk_out(input string p, input logic ov, input logic [31:0] res,
                           input logic [1:0] sb, input logic [3:0] tag, input logic src);
        chk({p, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({p, " out_result"}, out_result, res);
        chk({p, " out_sign"}, {30'd0, out_sign_bits}, {30'd0, sb});
        chk({p, " out_tag"}, {28'd0, out_tag}, {28'd0, tag});
        chk({p, " out_src"}, {31'd0, out_src}, {31'd0, src});
    endtask

    vec_t  tbl [14];
    lane_t idle, c0, c1, rl [2];
    // Transaction-level model state
    logic        m_ov, m_src, m_rr;
    logic [31:0] m_res;
    logic [1:0]  m_sb;
    logic [3:0]  m_tag;

    initial begin
        idle = ln(ALU_NOP, 4'd0, 0, 0, 0, 0);
        c0   = ln(BINARY, F_ADD, 32'd1, 32'd2, 32'd0, 4'd1);
        c1   = ln(MEM_ADDR, F_ADD, 32'h100, 32'd0, 32'd4, 4'd2);

        // Contention from reset, single lane, backpressure, drain+fire, flush, zero, negative.
        tbl[0]  = mkv(0, 1, 2'b11, c0, c1, 2'b01, BINARY,   1, 32'd3,   S_POS, 4'd1, 0);
        tbl[1]  = mkv(0, 1, 2'b11, c0, c1, 2'b10, MEM_ADDR, 1, 32'h104, S_POS, 4'd2, 1);
        tbl[2]  = mkv(0, 1, 2'b11, c0, c1, 2'b01, BINARY,   1, 32'd3,   S_POS, 4'd1, 0);
        tbl[3]  = mkv(0, 1, 2'b11, c0, c1, 2'b10, MEM_ADDR, 1, 32'h104, S_POS, 4'd2, 1);
        tbl[4]  = mkv(0, 1, 2'b01, ln(BINARY, F_ADD, 5, 7, 0, 3), idle,
                      2'b01, BINARY, 1, 32'd12, S_POS, 4'd3, 0);
        tbl[5]  = mkv(0, 0, 2'b11, c0, c1, 2'b00, ALU_NOP,  1, 32'd12,  S_POS, 4'd3, 0);
        tbl[6]  = mkv(0, 0, 2'b11, c0, c1, 2'b00, ALU_NOP,  1, 32'd12,  S_POS, 4'd3, 0);
        tbl[7]  = mkv(0, 0, 2'b11, c0, c1, 2'b00, ALU_NOP,  1, 32'd12,  S_POS, 4'd3, 0);
        tbl[8]  = mkv(0, 1, 2'b10, idle, c1, 2'b10, MEM_ADDR, 1, 32'h104, S_POS, 4'd2, 1);
        tbl[9]  = mkv(1, 1, 2'b11, c0, c1, 2'b00, ALU_NOP,  0, 32'h104, S_POS, 4'd2, 1);
        tbl[10] = mkv(0, 1, 2'b11, c0, c1, 2'b01, BINARY,   1, 32'd3,   S_POS, 4'd1, 0);
        tbl[11] = mkv(0, 1, 2'b01, ln(BRANCH_COND, F_SUB, 9, 9, 0, 5), idle,
                      2'b01, BRANCH_COND, 1, 32'd0, S_ZERO, 4'd5, 0);
        tbl[12] = mkv(0, 1, 2'b00, idle, idle, 2'b00, ALU_NOP, 0, 32'd0, S_ZERO, 4'd5, 0);
        tbl[13] = mkv(0, 1, 2'b10, idle, ln(BINARY, F_SUB, 3, 5, 0, 7),
                      2'b10, BINARY, 1, 32'hFFFF_FFFE, S_NEG, 4'd7, 1);

        rst = 1'b1;
        drive(0, 1, 2'b00, idle, idle);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 32'd0, 2'b00, 4'd0, 0);
        chk("reset req_ready", {30'd0, req_ready}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].flush, tbl[i].ordy, tbl[i].vld, tbl[i].l0, tbl[i].l1);
            #1;
            chk($sformatf("row%0d req_ready", i), {30'd0, req_ready}, {30'd0, tbl[i].e_rdy});
            chk($sformatf("row%0d alu_signal", i), {29'd0, alu_signal}, {29'd0, tbl[i].e_sig});
            @(posedge clk);
            #1;
            chk_out($sformatf("row%0d", i), tbl[i].e_ov, tbl[i].e_res, tbl[i].e_sb,
                    tbl[i].e_tag, tbl[i].e_src);
        end

        // Asynchronous reset between edges with a result held and rr pointing at lane 1.
        drive(0, 1, 2'b01, ln(BINARY, F_ADD, 8, 8, 0, 6), idle);
        @(posedge clk);
        #1;
        chk_out("pre-rst", 1, 32'h10, S_POS, 4'd6, 0);
        drive(0, 1, 2'b11, c0, c1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async rst", 0, 32'd0, 2'b00, 4'd0, 0);
        chk("rst req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst alu_signal", {29'd0, alu_signal}, {29'd0, ALU_NOP});
        @(posedge clk);
        #1;
        chk("rst held out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst held req_ready", {30'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst rr grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk_out("post-rst", 1, 32'd3, S_POS, 4'd1, 0);

        // Randomized traffic against the model, starting from a fresh reset.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_ov = 0; m_res = 0; m_sb = 0; m_tag = 0; m_src = 0; m_rr = 0;
        for (int c = 0; c < 300; c++) begin
            logic       fl, ordy, g_any, g;
            logic [1:0] vld, e_rdy;
            for (int k = 0; k < 2; k++) begin
                rl[k] = ln(3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), $urandom,
                           ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom,
                           4'($urandom));
                rl[k].pc = $urandom;
                if ($urandom_range(0, 3) == 0) rl[k].rs2 = rl[k].rs1;
            end
            fl   = ($urandom_range(0, 9) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            vld  = 2'($urandom_range(0, 3));
            drive(fl, ordy, vld, rl[0], rl[1]);

            g_any = !fl && (!m_ov || ordy) && (vld != 2'b00);
            g     = (vld == 2'b11) ? m_rr : vld[1];
            e_rdy = g_any ? (2'b01 << g) : 2'b00;
            #1;
            chk($sformatf("rnd%0d req_ready", c), {30'd0, req_ready}, {30'd0, e_rdy});
            chk($sformatf("rnd%0d alu_signal", c), {29'd0, alu_signal},
                {29'd0, g_any ? rl[g].sig : ALU_NOP});
            chk($sformatf("rnd%0d alu_func", c), {28'd0, alu_func_code},
                {28'd0, g_any ? rl[g].func : 4'd0});
            chk($sformatf("rnd%0d alu_rs1", c), alu_rs1, g_any ? rl[g].rs1 : 32'd0);
            chk($sformatf("rnd%0d alu_rs2", c), alu_rs2, g_any ? rl[g].rs2 : 32'd0);
            chk($sformatf("rnd%0d alu_imm", c), alu_imm, g_any ? rl[g].imm : 32'd0);
            chk($sformatf("rnd%0d alu_pc", c), alu_pc, g_any ? rl[g].pc : 32'd0);

            if (fl) begin
                m_ov = 0;
            end else if (g_any) begin
                m_ov  = 1;
                m_res = alu_fn(rl[g].sig, rl[g].func, rl[g].rs1, rl[g].rs2, rl[g].imm, rl[g].pc);
                m_sb  = sign_fn(m_res);
                m_tag = rl[g].tag;
                m_src = g;
                m_rr  = ~g;
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end
            @(posedge clk);
            #1;
            chk_out($sformatf("rnd%0d", c), m_ov, m_res, m_sb, m_tag, m_src);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
